// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_if
// Purpose  : Groups the fetch-side lookup channel, the execute-side training
//            channel and the statistics outputs of the branch predictor.
// Modports : master - fetch/execute side (drives requests, reads results)
//            slave  - predictor side (reads requests, drives results)
// Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int WORD_SIZE = 32
);
    // Lookup channel
    logic                 pred_valid;
    logic [WORD_SIZE-1:0] pred_pc;
    logic                 pred_out_valid;
    logic                 pred_taken;
    logic                 pred_hit;
    logic [WORD_SIZE-1:0] pred_target;

    // Training channel
    logic                 upd_valid;
    logic [WORD_SIZE-1:0] upd_pc;
    logic                 upd_taken;
    logic [WORD_SIZE-1:0] upd_target;
    logic                 upd_predicted_taken;

    // Statistics
    logic [31:0]          stat_branches;
    logic [31:0]          stat_mispredicts;

    modport master (
        output pred_valid, pred_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_predicted_taken,
        input  pred_out_valid, pred_taken, pred_hit, pred_target,
        input  stat_branches, stat_mispredicts
    );

    modport slave (
        input  pred_valid, pred_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_predicted_taken,
        output pred_out_valid, pred_taken, pred_hit, pred_target,
        output stat_branches, stat_mispredicts
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped table of 2-bit saturating counters with a tagged
//            branch target buffer. Registered one-cycle lookup; training from
//            resolved conditional branches; saturating statistics counters.
// Ports    : clk   - clock, all state changes on rising edge
//            rst_n - synchronous active-low reset
//            bp    - branch_predictor_if.slave (lookup, update, statistics)
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int WORD_SIZE  = 32,
    parameter int INDEX_BITS = 6
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS - 2;

    // Table storage
    logic                 r_valid  [ENTRIES];
    logic [TAG_W-1:0]     r_tag    [ENTRIES];
    logic [WORD_SIZE-1:0] r_target [ENTRIES];
    logic [1:0]           r_ctr    [ENTRIES];

    // Registered prediction
    logic                 r_pred_out_valid;
    logic                 r_pred_taken;
    logic                 r_pred_hit;
    logic [WORD_SIZE-1:0] r_pred_target;

    // Statistics
    logic [31:0]          r_branches;
    logic [31:0]          r_mispredicts;

    // Lookup side decode
    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_W-1:0]      w_lk_tag;
    logic                  w_lk_hit;
    logic                  w_lk_taken;

    assign w_lk_idx   = bp.pred_pc[INDEX_BITS+1:2];
    assign w_lk_tag   = bp.pred_pc[WORD_SIZE-1:INDEX_BITS+2];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];

    // Update side decode
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [TAG_W-1:0]      w_up_tag;
    logic                  w_up_hit;
    logic [1:0]            w_up_ctr;
    logic [1:0]            w_ctr_inc;
    logic [1:0]            w_ctr_dec;

    assign w_up_idx  = bp.upd_pc[INDEX_BITS+1:2];
    assign w_up_tag  = bp.upd_pc[WORD_SIZE-1:INDEX_BITS+2];
    assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr  = r_ctr[w_up_idx];
    assign w_ctr_inc = (w_up_ctr == 2'b11) ? 2'b11 : w_up_ctr + 2'b01;
    assign w_ctr_dec = (w_up_ctr == 2'b00) ? 2'b00 : w_up_ctr - 2'b01;

    // Instruction alignment bits never address the table.
    logic w_unused_upd_lsb;
    assign w_unused_upd_lsb = &{1'b0, bp.upd_pc[1:0]};

    // Table training. The lookup above reads the same arrays combinationally,
    // so a same-edge lookup sees the pre-update entry (no bypass).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (bp.upd_valid) begin
            if (w_up_hit) begin
                if (bp.upd_taken) begin
                    r_ctr[w_up_idx]    <= w_ctr_inc;
                    r_target[w_up_idx] <= bp.upd_target;
                end else begin
                    r_ctr[w_up_idx]    <= w_ctr_dec;
                end
            end else if (bp.upd_taken) begin
                // Taken miss installs (and may evict an aliasing entry).
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= bp.upd_target;
                r_ctr[w_up_idx]    <= 2'b10;
            end
        end
    end

    // Prediction register; outputs other than valid hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pred_out_valid <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_pred_hit       <= 1'b0;
            r_pred_target    <= '0;
        end else begin
            r_pred_out_valid <= bp.pred_valid;
            if (bp.pred_valid) begin
                r_pred_hit    <= w_lk_hit;
                r_pred_taken  <= w_lk_taken;
                r_pred_target <= w_lk_taken ? r_target[w_lk_idx]
                                            : bp.pred_pc + WORD_SIZE'(4);
            end
        end
    end

    // Saturating statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else if (bp.upd_valid) begin
            if (r_branches != 32'hFFFF_FFFF) begin
                r_branches <= r_branches + 32'd1;
            end
            if ((bp.upd_predicted_taken != bp.upd_taken) &&
                (r_mispredicts != 32'hFFFF_FFFF)) begin
                r_mispredicts <= r_mispredicts + 32'd1;
            end
        end
    end

    assign bp.pred_out_valid   = r_pred_out_valid;
    assign bp.pred_taken       = r_pred_taken;
    assign bp.pred_hit         = r_pred_hit;
    assign bp.pred_target      = r_pred_target;
    assign bp.stat_branches    = r_branches;
    assign bp.stat_mispredicts = r_mispredicts;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Self-checking bench for branch_predictor. A driver issues one
//            stimulus per cycle, evaluates an array-based reference model and
//            queues the expected post-edge outputs; a monitor pops and
//            compares one record after every edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
    logic clk;
    logic rst_n;

    branch_predictor_if #(.WORD_SIZE(32)) bif ();

    branch_predictor #(.WORD_SIZE(32), .INDEX_BITS(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ov;
        bit          hit;
        bit          tk;
        logic [31:0] tgt;
        logic [31:0] br;
        logic [31:0] mp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: 64 entries, index = (pc/4) mod 64, tag = pc/256
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    longint      m_br, m_mp;
    exp_t        m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_br = 0;
        m_mp = 0;
        m_last = '{ov: 1'b0, hit: 1'b0, tk: 1'b0, tgt: 32'h0, br: 32'h0, mp: 32'h0};
    endtask

    // One clock of stimulus; the expected result of this edge goes to sb.
    task automatic cyc(input bit rst, input bit pv, input logic [31:0] ppc,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input bit upt);
        int unsigned idx, tag;
        bit          h;
        @(negedge clk);
        rst_n                   = ~rst;
        bif.pred_valid          = pv;
        bif.pred_pc             = ppc;
        bif.upd_valid           = uv;
        bif.upd_pc              = upc;
        bif.upd_taken           = ut;
        bif.upd_target          = utgt;
        bif.upd_predicted_taken = upt;
        if (rst) begin
            model_reset();
        end else begin
            // Lookup uses the table as it was before this edge's update.
            m_last.ov = pv;
            if (pv) begin
                idx = (ppc / 4) % 64;
                tag = ppc / 256;
                h   = m_valid[idx] && (m_tag[idx] == tag);
                m_last.hit = h;
                m_last.tk  = h && (m_ctr[idx] >= 2);
                m_last.tgt = m_last.tk ? m_tgt[idx] : ppc + 32'd4;
            end
            if (uv) begin
                idx = (upc / 4) % 64;
                tag = upc / 256;
                h   = m_valid[idx] && (m_tag[idx] == tag);
                if (h && ut) begin
                    m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    m_tgt[idx] = utgt;
                end else if (h) begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end else if (ut) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tag;
                    m_tgt[idx]   = utgt;
                    m_ctr[idx]   = 2;
                end
                if (m_br < 64'hFFFF_FFFF) m_br++;
                if (upt != ut && m_mp < 64'hFFFF_FFFF) m_mp++;
            end
            m_last.br = m_br[31:0];
            m_last.mp = m_mp[31:0];
        end
        sb.push_back(m_last);
    endtask

    task automatic look(input logic [31:0] pc);
        cyc(0, 1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tg, input bit pt);
        cyc(0, 0, 0, 1, pc, t, tg, pt);
    endtask

    // Monitor: one expected record per clock edge after stimulus starts.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pred_out_valid",   {31'b0, bif.pred_out_valid}, {31'b0, e.ov});
                chk("pred_hit",         {31'b0, bif.pred_hit},       {31'b0, e.hit});
                chk("pred_taken",       {31'b0, bif.pred_taken},     {31'b0, e.tk});
                chk("pred_target",      bif.pred_target,             e.tgt);
                chk("stat_branches",    bif.stat_branches,           e.br);
                chk("stat_mispredicts", bif.stat_mispredicts,        e.mp);
            end
        end
    end

    initial begin
        logic [31:0] pc, pc2;
        rst_n                   = 1'b0;
        bif.pred_valid          = 1'b0;
        bif.pred_pc             = '0;
        bif.upd_valid           = 1'b0;
        bif.upd_pc              = '0;
        bif.upd_taken           = 1'b0;
        bif.upd_target          = '0;
        bif.upd_predicted_taken = 1'b0;
        model_reset();

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h100, 1, 32'h100, 1, 32'h300, 1); // ignored during reset

        // Cold lookup
        look(32'h100);
        // Install and train down
        upd(32'h100, 1, 32'h200, 0);
        look(32'h100);
        upd(32'h100, 0, 0, 1);
        upd(32'h100, 0, 0, 1);
        look(32'h100);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);                   // idle: outputs hold

        // Saturation after fresh reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        upd(32'h100, 1, 32'h210, 1);
        upd(32'h100, 1, 32'h220, 1);
        upd(32'h100, 1, 32'h230, 1);
        upd(32'h100, 1, 32'h240, 1);
        upd(32'h100, 0, 0, 1);
        look(32'h100);

        // Aliasing at index 0
        look(32'h200);
        upd(32'h200, 0, 0, 0);
        look(32'h100);
        upd(32'h200, 1, 32'h400, 0);
        look(32'h100);
        look(32'h200);

        // Same-edge collision with counter 01, then mispredict stats
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        upd(32'h104, 1, 32'h500, 1);
        upd(32'h104, 0, 0, 1);
        cyc(0, 1, 32'h104, 1, 32'h104, 1, 32'h500, 0);
        look(32'h104);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        upd(32'h108, 1, 32'h10, 1);
        upd(32'h108, 0, 0, 1);
        upd(32'h108, 1, 32'h20, 0);

        // PC wrap on fall-through target
        look(32'hFFFF_FFFC);

        // Randomized traffic over a small PC pool to force hits and aliasing
        for (int i = 0; i < 600; i++) begin
            pc  = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00} | 32'h1000;
            pc2 = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00} | 32'h1000;
            if ($urandom_range(0, 99) < 2) begin
                cyc(1, $urandom_range(0, 1), pc, 1, pc2, 1, $urandom, 1);
            end else begin
                cyc(0, $urandom_range(0, 3) != 0, pc,
                    $urandom_range(0, 2) != 0, pc2, $urandom_range(0, 2) != 0,
                    $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
            end
        end

        // Mid-stream reset during an update, then probe trained PCs
        upd(32'h3000, 1, 32'h44, 0);
        cyc(1, 0, 0, 1, 32'h3004, 1, 32'h48, 0);
        look(32'h3000);
        look(32'h1000);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the RISC-V core: a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer. Fetch presents a PC and receives a registered taken/target prediction one cycle later. The execute stage reports each resolved conditional branch (its actual outcome from the branch comparator), which trains the table and updates the prediction statistics counters.

## Interface
- WORD_SIZE, 32, width of PCs and targets
- INDEX_BITS, 6, log2 of table entries (64); index = pc[INDEX_BITS+1:2], tag = pc[WORD_SIZE-1:INDEX_BITS+2]

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- pred_valid  in  1  lookup request this cycle
- pred_pc  in  WORD_SIZE  PC of the fetched instruction
- pred_out_valid  out  1  prediction result valid (pred_valid delayed one cycle)
- pred_taken  out  1  predicted taken
- pred_hit  out  1  BTB tag hit
- pred_target  out  WORD_SIZE  predicted next PC
- upd_valid  in  1  resolved conditional branch this cycle
- upd_pc  in  WORD_SIZE  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  WORD_SIZE  computed branch target
- upd_predicted_taken  in  1  prediction that was used for this branch
- stat_branches  out  32  resolved-branch count
- stat_mispredicts  out  32  mispredict count

## Operation
- Per entry: valid bit, tag, target, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Lookup at edge with pred_valid=1: registers hit = valid && tag match; pred_taken = hit && counter[1]; pred_target = hit && counter[1] ? stored target : pred_pc+4 (modulo 2^WORD_SIZE); pred_out_valid=1. pred_valid=0: pred_out_valid=0 and the other prediction outputs hold their previous values.
- Update at edge with upd_valid=1, entry at upd_pc index:
  - tag hit, taken: counter saturating +1 (11 stays 11); target overwritten with upd_target.
  - tag hit, not taken: counter saturating -1 (00 stays 00).
  - miss (invalid or tag mismatch), taken: install entry: valid=1, tag, target, counter=10.
  - miss, not taken: no table change.
- Statistics on upd_valid: stat_branches +1; stat_mispredicts +1 when upd_predicted_taken != upd_taken. Both saturate at 32'hFFFFFFFF.
- Only the indexed entry changes per update; aliasing PCs with different tags evict each other only on taken installs.

## Timing
- Lookup latency: 1 cycle (request at edge N, outputs valid after edge N until edge N+1); one lookup per cycle, no stall.
- Update takes effect at the edge it is sampled; visible to lookups sampled at the following edge or later.
- Simultaneous lookup and update to the same index at the same edge: lookup returns the pre-update entry (read-before-write, no bypass).
- Reset (rst_n=0 at a rising edge, any cycle including mid-stream): all valid bits 0, all counters 01, targets/tags 0; pred_out_valid=0, pred_taken=0, pred_hit=0, pred_target=0; both stat counters 0. Inputs presented during reset are ignored; lookups/updates in flight are discarded.
- First lookup after reset release: sampled at the first edge with rst_n=1.

## Test plan
- Cold: reset, lookup pc=0x100 -> next cycle pred_out_valid=1, pred_hit=0, pred_taken=0, pred_target=0x104.
- Install/train: update pc=0x100 taken target=0x200, then lookup 0x100 -> hit=1, taken=1, target=0x200; two not-taken updates -> counter 00, lookup -> hit=1, taken=0, target=0x104.
- Saturation: four taken updates on 0x100 then one not-taken -> counter 10, still predicts taken to latest target; stat_branches=5.
- Aliasing: install 0x100 taken, then lookup 0x200 (INDEX_BITS=6, same index 0) -> hit=0, taken=0; not-taken update at 0x200 leaves 0x100 entry intact; taken update at 0x200 evicts it.
- Same-edge collision: entry counter 01, lookup and taken update on same PC at the same edge -> prediction not-taken; next-cycle lookup -> taken. Mispredict stats: 3 updates with predicted/actual (1,1),(1,0),(0,1) -> stat_branches=3, stat_mispredicts=2.
- Mid-operation reset: train several entries, assert rst_n=0 for one edge concurrently with upd_valid=1 -> all outputs and stats 0; subsequent lookup of any trained PC -> hit=0.
